// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: data widths and the load-type encoding
// consumed by the load-extension logic.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    LD_WORD   = 2'd0,
    LD_HALF_S = 2'd1,
    LD_HALF_U = 2'd2
  } ld_type_e;

endpackage

// File: rtl/load_extender.sv
// Pure combinational load extension: passes a word through or sign/zero-extends
// its low halfword. lh takes priority over lhu.
module load_extender
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic              lh,
  input  logic              lhu,
  output logic [DATA_W-1:0] result
);

  ld_type_e ld_type;

  always_comb begin
    ld_type = LD_WORD;
    if (lh) begin
      ld_type = LD_HALF_S;
    end else if (lhu) begin
      ld_type = LD_HALF_U;
    end
  end

  always_comb begin
    result = word;
    case (ld_type)
      LD_HALF_S: result = {{(DATA_W-HALF_W){word[HALF_W-1]}}, word[HALF_W-1:0]};
      LD_HALF_U: result = {{(DATA_W-HALF_W){1'b0}}, word[HALF_W-1:0]};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-indexed data RAM for the MEM stage: synchronous clear/write, combinational
// read with halfword extension. Define DATAMEM_BOUNDS_CHECK_EN to add addr_err.
module data_memory #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       address,
  input  logic              MemRead,
  input  logic              MemWrite,
`ifdef DATAMEM_BOUNDS_CHECK_EN
  output logic              addr_err,
`endif
  input  logic              lh,
  input  logic              lhu
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  assign idx = address[IDX_W-1:0];

`ifdef DATAMEM_BOUNDS_CHECK_EN
  assign in_range = (address < 32'(DEPTH));
  assign addr_err = ~in_range & (MemRead | MemWrite);
`else
  // Upper index bits are ignored so addresses wrap modulo DEPTH.
  logic unused_addr_hi;
  assign in_range       = 1'b1;
  assign unused_addr_hi = ^address[31:IDX_W];
`endif

  // Reset clears the whole array and wins over a concurrent write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite && in_range) begin
      mem[idx] <= data_in;
    end
  end

  always_comb begin
    rd_word = '0;
    if (MemRead && in_range) begin
      rd_word = mem[idx];
    end
  end

  load_extender u_load_extender (
    .word   (rd_word),
    .lh     (lh),
    .lhu    (lhu),
    .result (data_out)
  );

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; covers reset clear, word and
// halfword loads, read gating, write-through timing and address wrap/bounds.
module tb_data_memory;

  logic        Clk;
  logic        Reset;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic [31:0] address;
  logic        MemRead;
  logic        MemWrite;
  logic        lh;
  logic        lhu;
`ifdef DATAMEM_BOUNDS_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  data_memory dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .data_out (data_out),
    .data_in  (data_in),
    .address  (address),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
`ifdef DATAMEM_BOUNDS_CHECK_EN
    .addr_err (addr_err),
`endif
    .lh       (lh),
    .lhu      (lhu)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    address  = addr;
    data_in  = data;
    MemWrite = 1'b1;
    @(posedge Clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr,
                            input logic l_h, input logic l_hu, input logic [31:0] exp);
    address = addr;
    MemRead = 1'b1;
    lh      = l_h;
    lhu     = l_hu;
    #1;
    check(tag, data_out, exp);
    lh  = 1'b0;
    lhu = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    lh       = 1'b0;
    lhu      = 1'b0;
    address  = 32'd50;
    data_in  = 32'd0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("reset_addr50", data_out, 32'd0);
    for (int i = 0; i < 256; i++) begin
      read_check($sformatf("reset_word%0d", i), 32'(i), 1'b0, 1'b0, 32'd0);
    end

    // Word writes then read-back.
    write_word(32'd50, 32'd1200);
    write_word(32'd63, 32'd5400);
    write_word(32'd40, 32'd131071);
    read_check("rd50", 32'd50, 1'b0, 1'b0, 32'd1200);
    read_check("rd63", 32'd63, 1'b0, 1'b0, 32'd5400);
    read_check("rd40", 32'd40, 1'b0, 1'b0, 32'd131071);

    // Halfword extension on 0x0001FFFF.
    read_check("lhu40",     32'd40, 1'b0, 1'b1, 32'h0000_FFFF);
    read_check("lh40",      32'd40, 1'b1, 1'b0, 32'hFFFF_FFFF);
    read_check("lh_lhu40",  32'd40, 1'b1, 1'b1, 32'hFFFF_FFFF);
    read_check("lhu63",     32'd63, 1'b0, 1'b1, 32'd5400);
    write_word(32'd40, 32'h0001_7FFF);
    read_check("lh40_pos",  32'd40, 1'b1, 1'b0, 32'd32767);
    read_check("word40_7f", 32'd40, 1'b0, 1'b0, 32'h0001_7FFF);

    // Extension is independent of MemWrite; stores a negative halfword pattern.
    write_word(32'd41, 32'h1234_8001);
    read_check("lh41",  32'd41, 1'b1, 1'b0, 32'hFFFF_8001);
    read_check("lhu41", 32'd41, 1'b0, 1'b1, 32'h0000_8001);

    // MemRead gating and no-write edges.
    address = 32'd50;
    MemRead = 1'b0;
    #1;
    check("noread50", data_out, 32'd0);
    data_in = 32'hDEAD_BEEF;
    repeat (3) @(posedge Clk);
    #1;
    read_check("nowrite50", 32'd50, 1'b0, 1'b0, 32'd1200);

    // Same-cycle read/write at 63.
    address  = 32'd63;
    data_in  = 32'd7;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    #1;
    check("rw63_before", data_out, 32'd5400);
    @(posedge Clk);
    #1;
    MemWrite = 1'b0;
    check("rw63_after", data_out, 32'd7);

    // Address beyond DEPTH.
`ifdef DATAMEM_BOUNDS_CHECK_EN
    address  = 32'd261;
    data_in  = 32'd99;
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    #1;
    check("addr_err_wr", 32'(addr_err), 32'd1);
    @(posedge Clk);
    #1;
    MemWrite = 1'b0;
    #1;
    check("addr_err_idle", 32'(addr_err), 32'd0);
    read_check("oob_rd261", 32'd261, 1'b0, 1'b0, 32'd0);
    check("addr_err_rd", 32'(addr_err), 32'd1);
    read_check("oob_rd5", 32'd5, 1'b0, 1'b0, 32'd0);
    check("addr_err_inrange", 32'(addr_err), 32'd0);
`else
    write_word(32'd261, 32'd99);
    read_check("wrap_rd5",   32'd5,   1'b0, 1'b0, 32'd99);
    read_check("wrap_rd261", 32'd261, 1'b0, 1'b0, 32'd99);
    read_check("wrap_rd517", 32'd517, 1'b0, 1'b0, 32'd99);
`endif

    // Reset wins over a concurrent write and clears the array again.
    address  = 32'd50;
    data_in  = 32'd123;
    MemWrite = 1'b1;
    Reset    = 1'b1;
    @(posedge Clk);
    #1;
    Reset    = 1'b0;
    MemWrite = 1'b0;
    read_check("rst_prio50", 32'd50, 1'b0, 1'b0, 32'd0);
    read_check("rst_clr63",  32'd63, 1'b0, 1'b0, 32'd0);
    read_check("rst_clr40",  32'd40, 1'b1, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
